// File: rtl/line_packer.sv
// line_packer: packs the camera's 8-bit sample stream into 128-bit words for
// the line FIFO feeding the droplet detector. Every accepted line produces
// exactly WordsPerLine words. A truncated line is zero-padded to full length.
// A line that starts while the FIFO lacks room for a full line is dropped whole.
//
// Optional feature: define LINE_PACK_BLACKLEVEL_EN to subtract BlackLevel
// from every accepted sample, saturating at 0, before packing.
//
// Ports:
//   clk          system clock (posedge)
//   reset        asynchronous active-low reset
//   ce           clock enable; when low every register holds except wrfifo (cleared)
//   pix_valid    pix_data carries a sample this cycle
//   pix_data     8-bit sample
//   line_start   first sample of a line (qualified by pix_valid)
//   wralmostfull FIFO has fewer than WordsPerLine free words (sampled at line_start)
//   wrfull       FIFO full; only used to flag ovferr
//   wrfifo       one-cycle write strobe
//   wrdata       packed word, first sample in [7:0]
//   linecount    lines written (wraps)
//   dropcount    lines dropped (saturates)
//   ovferr       sticky: a write was issued while wrfull was high
//   stateoutput  current state for debug (Idle=0, Pack=1, Pad=2, Drop=3)
module line_packer #(
  parameter int unsigned LineLen    = 336,
  parameter logic [7:0]  BlackLevel = 8'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         pix_valid,
  input  logic [7:0]   pix_data,
  input  logic         line_start,
  input  logic         wralmostfull,
  input  logic         wrfull,
  output logic         wrfifo,
  output logic [127:0] wrdata,
  output logic [15:0]  linecount,
  output logic [15:0]  dropcount,
  output logic         ovferr,
  output logic [1:0]   stateoutput
);

  localparam int unsigned WordsPerLine = LineLen / 16;
  localparam int unsigned WIdxW        = $clog2(WordsPerLine + 1);
  localparam logic [WIdxW-1:0] LastWord = WIdxW'(WordsPerLine - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_PAD  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       byte_idx;
  logic [WIdxW-1:0] word_idx;
  // Only bytes 0..14 are stored; byte 15 goes straight into wrdata.
  // Unwritten bytes are kept at zero so a partial word is already zero-filled.
  logic [119:0]     bytes;
  logic [7:0]       sample;

`ifdef LINE_PACK_BLACKLEVEL_EN
  always_comb begin
    sample = (pix_data > BlackLevel) ? (pix_data - BlackLevel) : '0;
  end
`else
  logic [7:0] unused_black;
  assign unused_black = BlackLevel;
  always_comb begin
    sample = pix_data;
  end
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign stateoutput = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      byte_idx  <= '0;
      word_idx  <= '0;
      bytes     <= '0;
      wrfifo    <= 1'b0;
      wrdata    <= '0;
      linecount <= '0;
      dropcount <= '0;
      ovferr    <= 1'b0;
    end else begin
      // The strobe reaches the FIFO regardless of ce, so the overflow flag
      // watches every strobe cycle.
      if (wrfifo && wrfull) ovferr <= 1'b1;
      wrfifo <= 1'b0;
      if (ce) begin
        unique case (state)
          S_IDLE, S_DROP: begin
            if (pix_valid && line_start) begin
              if (!wralmostfull) begin
                bytes    <= {112'd0, sample};
                byte_idx <= 4'd1;
                word_idx <= '0;
                state    <= S_PACK;
              end else begin
                dropcount <= sat_inc(dropcount);
                state     <= S_DROP;
              end
            end
          end
          S_PACK: begin
            if (pix_valid) begin
              if (line_start) begin
                // Truncated line: flush the partial word and pad the rest.
                // The new line's first sample is discarded and the line dropped.
                wrfifo    <= 1'b1;
                wrdata    <= {8'd0, bytes};
                bytes     <= '0;
                byte_idx  <= '0;
                dropcount <= sat_inc(dropcount);
                if (word_idx == LastWord) begin
                  word_idx  <= '0;
                  linecount <= linecount + 16'd1;
                  state     <= S_DROP;
                end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= S_PAD;
                end
              end else if (byte_idx == 4'd15) begin
                wrfifo   <= 1'b1;
                wrdata   <= {sample, bytes};
                bytes    <= '0;
                byte_idx <= '0;
                if (word_idx == LastWord) begin
                  word_idx  <= '0;
                  linecount <= linecount + 16'd1;
                  state     <= S_IDLE;
                end else begin
                  word_idx <= word_idx + 1'b1;
                end
              end else begin
                bytes[{byte_idx, 3'b000} +: 8] <= sample;
                byte_idx <= byte_idx + 4'd1;
              end
            end
          end
          S_PAD: begin
            wrfifo <= 1'b1;
            wrdata <= '0;
            if (word_idx == LastWord) begin
              word_idx  <= '0;
              linecount <= linecount + 16'd1;
              state     <= S_DROP;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_packer.sv
// Scoreboard bench for line_packer. The stimulus side keeps a line-level
// model (which lines are accepted, the bytes of the word being assembled,
// how many words each line owes) and queues every expected word with the
// cycle it must appear in. A monitor pops and compares on every strobe.
module tb_line_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         line_start;
  logic         wralmostfull;
  logic         wrfull;
  logic         wrfifo;
  logic [127:0] wrdata;
  logic [15:0]  linecount;
  logic [15:0]  dropcount;
  logic         ovferr;
  logic [1:0]   stateoutput;

`ifdef LINE_PACK_BLACKLEVEL_EN
  localparam logic [7:0] BL = 8'h10;
`else
  localparam logic [7:0] BL = 8'h00;
`endif

  line_packer #(.LineLen(336), .BlackLevel(BL)) dut (
    .clk(clk), .reset(reset), .ce(ce), .pix_valid(pix_valid),
    .pix_data(pix_data), .line_start(line_start), .wralmostfull(wralmostfull),
    .wrfull(wrfull), .wrfifo(wrfifo), .wrdata(wrdata), .linecount(linecount),
    .dropcount(dropcount), .ovferr(ovferr), .stateoutput(stateoutput)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  logic [127:0] seen[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // Reference model state
  logic [7:0] acc[$];
  bit         open_line = 1'b0;
  int         words_done = 0;
  int         exp_lines = 0;
  int         exp_drops = 0;
  bit         exp_ovf = 1'b0;
  int         exp_state = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] xf(input logic [7:0] v);
`ifdef LINE_PACK_BLACKLEVEL_EN
    return (v > BL) ? v - BL : 8'h00;
`else
    return v;
`endif
  endfunction

  function automatic logic [127:0] pack_acc();
    logic [127:0] w = '0;
    foreach (acc[i]) w[8*i +: 8] = acc[i];
    return w;
  endfunction

  function automatic void push_word(input logic [127:0] w, input int c);
    exp_t e;
    e.data = w;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  function automatic void add_sample(input logic [7:0] v, input int d);
    acc.push_back(xf(v));
    if (acc.size() == 16) begin
      push_word(pack_acc(), d + 1);
      acc.delete();
      words_done++;
      if (words_done == 21) begin
        open_line  = 1'b0;
        words_done = 0;
        exp_lines++;
        exp_state = 0;
      end
    end
  endfunction

  // Partial word one cycle after the truncating line_start, then zero words
  // back to back until the line has its 21 words.
  function automatic void truncate(input int d);
    int c = d + 2;
    push_word(pack_acc(), d + 1);
    acc.delete();
    words_done++;
    while (words_done < 21) begin
      push_word('0, c);
      c++;
      words_done++;
    end
    words_done = 0;
    open_line  = 1'b0;
    exp_lines++;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && wrfifo === 1'b1) begin
      seen.push_back(wrdata);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        check("word_data", wrdata, e.data);
        check("word_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      ce           = 1'b1;
      pix_valid    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_data     = 8'($urandom);
      line_start   = 1'b0;
      wralmostfull = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // nce0 cycles with ce low (garbage on the inputs), npv0 cycles with
  // pix_valid low, then the sample itself. d is the cycle it is driven in.
  task automatic drive(input logic [7:0] v, input bit ls, input bit af,
                       input int nce0, input int npv0, output int d);
    for (int i = 0; i < nce0; i++) begin
      ce = 1'b0; pix_valid = 1'b1; pix_data = 8'($urandom);
      line_start = 1'($urandom_range(0, 1));
      step();
    end
    for (int i = 0; i < npv0; i++) begin
      ce = 1'b1; pix_valid = 1'b0; pix_data = 8'($urandom);
      line_start = 1'($urandom_range(0, 1));
      step();
    end
    ce = 1'b1; pix_valid = 1'b1; pix_data = v; line_start = ls; wralmostfull = af;
    d = cyc;
    step();
    pix_valid = 1'b0;
    line_start = 1'b0;
  endtask

  // mode 0: back to back, 1: every other cycle plus a 5-cycle ce=0 hole,
  // 2: random holes and random wralmostfull inside the line.
  task automatic send_line(input int n, input bit af, input int mode, input bit rnd);
    bit accepting = 1'b0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] v;
      int nce0, npv0, d;
      bit afv;
      v    = rnd ? 8'($urandom) : 8'(k);
      nce0 = 0;
      npv0 = 0;
      case (mode)
        1: begin npv0 = (k > 0) ? 1 : 0; nce0 = (k == 8) ? 5 : 0; end
        2: begin
          npv0 = $urandom_range(0, 2);
          nce0 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
        end
        default: ;
      endcase
      afv = (k == 0) ? af : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      drive(v, k == 0, afv, nce0, npv0, d);
      if (k == 0) begin
        if (open_line) begin
          truncate(d);
          exp_drops++;
          exp_state = 3;
          idle(25, 1'b0);
        end else if (af) begin
          exp_drops++;
          exp_state = 3;
        end else begin
          open_line  = 1'b1;
          accepting  = 1'b1;
          words_done = 0;
          acc.delete();
          add_sample(v, d);
        end
      end else if (accepting) begin
        add_sample(v, d);
      end
    end
  endtask

  task automatic check_counters(input string tag);
    idle(4, 1'b0);
    check({tag, "_linecount"}, 128'(linecount), 128'(exp_lines[15:0]));
    check({tag, "_dropcount"}, 128'(dropcount), 128'(exp_drops[15:0]));
    check({tag, "_ovferr"}, 128'(ovferr), 128'(exp_ovf));
    check({tag, "_state"}, 128'(stateoutput), 128'(exp_state));
    check({tag, "_pending"}, 128'(q.size()), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, pending words %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ce = 1'b0; pix_valid = 1'b0; pix_data = '0;
    line_start = 1'b0; wralmostfull = 1'b0; wrfull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrfifo", 128'(wrfifo), 128'(0));
    check("rst_wrdata", wrdata, 128'(0));
    check("rst_linecount", 128'(linecount), 128'(0));
    check("rst_dropcount", 128'(dropcount), 128'(0));
    check("rst_ovferr", 128'(ovferr), 128'(0));
    check("rst_state", 128'(stateoutput), 128'(0));
    reset = 1'b1;
    idle(3, 1'b1);

    // Full line, consecutive samples
    seen.delete();
    send_line(336, 1'b0, 0, 1'b0);
    check_counters("full");
    if (seen.size() < 21) begin
      n_checks++; n_fail++;
      $display("FAIL full_wordcount: got %0d, expected 21", seen.size());
    end else begin
`ifndef LINE_PACK_BLACKLEVEL_EN
      check("full_word0", seen[0], 128'h0F0E0D0C0B0A09080706050403020100);
      check("full_word20_b0", 128'(seen[20][7:0]), 128'(8'h40));
`else
      check("bl_sample05", 128'(seen[0][47:40]), 128'(8'h00));
      check("bl_sample20", 128'(seen[2][7:0]), 128'(8'h10));
`endif
    end

    // Gapped input with a ce=0 hole mid-word
    send_line(336, 1'b0, 1, 1'b0);
    check_counters("gapped");

    // Truncated line, dropped truncating line, then a normal line
    send_line(40, 1'b0, 0, 1'b0);
    send_line(10, 1'b0, 0, 1'b0);
    check_counters("trunc");
    send_line(336, 1'b0, 0, 1'b0);
    check_counters("after_trunc");

    // Almost full at line_start, deasserted mid-line
    send_line(336, 1'b1, 0, 1'b0);
    check_counters("almostfull");
    send_line(336, 1'b0, 0, 1'b1);
    check_counters("after_af");

    // Random lines
    for (int i = 0; i < 14; i++) begin
      int n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 335) : 336;
      send_line(n, ($urandom_range(0, 3) == 0), 2, 1'b1);
      if (!open_line) begin
        idle($urandom_range(0, 6), 1'b1);
        check_counters("rand");
      end
    end
    if (open_line) send_line(1, 1'b0, 0, 1'b1);
    check_counters("rand_end");

    // Overflow flag
    wrfull = 1'b1;
    send_line(336, 1'b0, 0, 1'b1);
    exp_ovf = 1'b1;
    idle(2, 1'b0);
    wrfull = 1'b0;
    check_counters("ovf");

    // Reset mid-line
    send_line(20, 1'b0, 0, 1'b1);
    check("pre_rst_state", 128'(stateoutput), 128'(1));
    check("pre_rst_ovferr", 128'(ovferr), 128'(1));
    reset = 1'b0;
    #1;
    check("midrst_wrfifo", 128'(wrfifo), 128'(0));
    check("midrst_wrdata", wrdata, 128'(0));
    check("midrst_linecount", 128'(linecount), 128'(0));
    check("midrst_dropcount", 128'(dropcount), 128'(0));
    check("midrst_ovferr", 128'(ovferr), 128'(0));
    check("midrst_state", 128'(stateoutput), 128'(0));
    q.delete();
    acc.delete();
    open_line = 1'b0; words_done = 0; exp_lines = 0; exp_drops = 0;
    exp_ovf = 1'b0; exp_state = 0;
    step();
    step();
    reset = 1'b1;
    step();
    send_line(336, 1'b0, 0, 1'b1);
    check_counters("recover");

    idle(50, 1'b0);
    check("final_pending", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
